// File: rtl/cpu_pkg.sv
// ============================================================================
// Module  : cpu_pkg
// Purpose : Shared widths, opcode constants and the fetch state encoding for
//           the CPU front end.
// Ports   : none (package)
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

  localparam int ADDR_W  = 8;
  localparam int INSTR_W = 16;
  localparam int OPC_W   = 5;

  // Opcode lives in the top five bits of every instruction word.
  localparam logic [OPC_W-1:0] OPC_NOP  = 5'b00000;
  localparam logic [OPC_W-1:0] OPC_HALT = 5'b00001;
  localparam logic [OPC_W-1:0] OPC_ADD  = 5'b00010;
  localparam logic [OPC_W-1:0] OPC_SUB  = 5'b00011;
  localparam logic [OPC_W-1:0] OPC_LD   = 5'b00100;
  localparam logic [OPC_W-1:0] OPC_ST   = 5'b00101;
  localparam logic [OPC_W-1:0] OPC_BR   = 5'b00110;

  localparam logic [INSTR_W-1:0] NOP_WORD = 16'h0000;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } fetch_state_t;

  function automatic logic is_halt(input logic [INSTR_W-1:0] instr);
    return instr[INSTR_W-1 -: OPC_W] == OPC_HALT;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_stage_if.sv
// ============================================================================
// Module  : fetch_stage_if
// Purpose : Control, instruction-memory and IF/ID signals of the fetch stage.
// Ports   : enable, stall, redirect, redirect_pc, imem_rdata (into fetch);
//           imem_addr, id_instr, id_pc, id_valid, halted (out of fetch).
//           Modport slave = fetch stage, master = surrounding CPU / memory.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fetch_stage_if;
  import cpu_pkg::*;

  logic                enable;
  logic                stall;
  logic                redirect;
  logic [ADDR_W-1:0]   redirect_pc;
  logic [ADDR_W-1:0]   imem_addr;
  logic [INSTR_W-1:0]  imem_rdata;
  logic [INSTR_W-1:0]  id_instr;
  logic [ADDR_W-1:0]   id_pc;
  logic                id_valid;
  logic                halted;

  modport slave (
    input  enable, stall, redirect, redirect_pc, imem_rdata,
    output imem_addr, id_instr, id_pc, id_valid, halted
  );

  modport master (
    output enable, stall, redirect, redirect_pc, imem_rdata,
    input  imem_addr, id_instr, id_pc, id_valid, halted
  );

endinterface

`default_nettype wire

// File: rtl/fetch_stage_if_id_reg.sv
// ============================================================================
// Module  : if_id_reg
// Purpose : IF/ID pipeline register. Flush inserts a bubble (NOP, invalid,
//           address kept), hold freezes all fields, otherwise it captures the
//           fetched word and its address as a valid instruction.
// Ports   : clk, reset (async, active high), i_flush, i_hold, i_instr, i_pc,
//           o_instr, o_pc, o_valid.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module if_id_reg
  import cpu_pkg::*;
(
  input  wire logic               clk,
  input  wire logic               reset,
  input  wire logic               i_flush,
  input  wire logic               i_hold,
  input  wire logic [INSTR_W-1:0] i_instr,
  input  wire logic [ADDR_W-1:0]  i_pc,
  output logic      [INSTR_W-1:0] o_instr,
  output logic      [ADDR_W-1:0]  o_pc,
  output logic                    o_valid
);

  logic [INSTR_W-1:0] r_instr;
  logic [ADDR_W-1:0]  r_pc;
  logic               r_valid;

  // Flush outranks hold so a redirect arriving with a stall still squashes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_instr <= NOP_WORD;
      r_pc    <= '0;
      r_valid <= 1'b0;
    end else if (i_flush) begin
      r_instr <= NOP_WORD;
      r_valid <= 1'b0;
    end else if (!i_hold) begin
      r_instr <= i_instr;
      r_pc    <= i_pc;
      r_valid <= 1'b1;
    end
  end

  assign o_instr = r_instr;
  assign o_pc    = r_pc;
  assign o_valid = r_valid;

endmodule

`default_nettype wire

// File: rtl/fetch_stage.sv
// ============================================================================
// Module  : fetch_stage
// Purpose : Instruction fetch: PC register, IDLE/RUN/HALTED control and the
//           IF/ID register. Redirect beats disable beats stall beats advance.
// Ports   : clk, reset (async, active high), bus (fetch_stage_if.slave).
// Params  : RESET_PC - PC loaded on reset.
// Config  : FETCH_HALT_STOP_EN - when defined, a fetched HALT opcode freezes
//           the PC and parks the stage in HALTED until a redirect.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_stage
  import cpu_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = 8'h00
) (
  input  wire logic   clk,
  input  wire logic   reset,
  fetch_stage_if.slave bus
);

  fetch_state_t      r_state;
  fetch_state_t      w_state_nxt;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] w_pc_nxt;
  logic              w_flush;
  logic              w_hold;
  logic              w_halt_word;

`ifdef FETCH_HALT_STOP_EN
  assign w_halt_word = is_halt(bus.imem_rdata);
  assign bus.halted  = (r_state == ST_HALTED);
`else
  assign w_halt_word = 1'b0;
  assign bus.halted  = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_pc    <= RESET_PC;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
    end
  end

  // IF/ID action is load whenever neither flush nor hold is raised.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_flush     = 1'b0;
    w_hold      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_flush = 1'b1;
        if (bus.redirect)
          w_pc_nxt = bus.redirect_pc;
        else if (bus.enable)
          w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (bus.redirect) begin
          w_flush  = 1'b1;
          w_pc_nxt = bus.redirect_pc;
        end else if (!bus.enable) begin
          w_flush     = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (bus.stall) begin
          w_hold = 1'b1;
        end else if (w_halt_word) begin
          // HALT is latched as a valid instruction, PC stays on it.
          w_state_nxt = ST_HALTED;
        end else begin
          w_pc_nxt = r_pc + 8'd1;
        end
      end
      ST_HALTED: begin
        if (bus.redirect) begin
          w_flush     = 1'b1;
          w_pc_nxt    = bus.redirect_pc;
          w_state_nxt = ST_RUN;
        end else if (bus.stall) begin
          w_hold = 1'b1;
        end else begin
          w_flush = 1'b1;
        end
      end
      default: begin
        w_flush     = 1'b1;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign bus.imem_addr = r_pc;

  if_id_reg u_if_id_reg (
    .clk     (clk),
    .reset   (reset),
    .i_flush (w_flush),
    .i_hold  (w_hold),
    .i_instr (bus.imem_rdata),
    .i_pc    (r_pc),
    .o_instr (bus.id_instr),
    .o_pc    (bus.id_pc),
    .o_valid (bus.id_valid)
  );

endmodule

`default_nettype wire
